// File: rtl/swervolf_gpio_bank.sv
// GPIO bank: synchronised, debounced and edge-detected inputs with pending/IRQ
// logic, plus masked-write registered outputs.
module swervolf_gpio_bank #(
  parameter int IN_WIDTH        = 16,
  parameter int OUT_WIDTH       = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IN_WIDTH-1:0]  i_pin,
  output logic [IN_WIDTH-1:0]  o_level,
  output logic [IN_WIDTH-1:0]  o_rise,
  output logic [IN_WIDTH-1:0]  o_fall,
  input  logic [IN_WIDTH-1:0]  i_rise_en,
  input  logic [IN_WIDTH-1:0]  i_fall_en,
  input  logic [IN_WIDTH-1:0]  i_irq_en,
  input  logic [IN_WIDTH-1:0]  i_pend_clr,
  output logic [IN_WIDTH-1:0]  o_pending,
  output logic                 o_irq,
  input  logic [OUT_WIDTH-1:0] i_out,
  input  logic [OUT_WIDTH-1:0] i_out_mask,
  input  logic                 i_out_we,
  output logic [OUT_WIDTH-1:0] o_pin
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0] s;
  logic [CW-1:0]       cnt      [IN_WIDTH];
  logic [CW-1:0]       cnt_next [IN_WIDTH];
  logic [IN_WIDTH-1:0] level_next;
  logic [IN_WIDTH-1:0] rise_next;
  logic [IN_WIDTH-1:0] fall_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_pin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A change is accepted only after it has been stable for the full count.
  always_comb begin
    level_next = o_level;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != o_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = s[i];
          rise_next[i]  = s[i];
          fall_next[i]  = ~s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
      o_level   <= '0;
      o_rise    <= '0;
      o_fall    <= '0;
      o_pending <= '0;
      o_irq     <= 1'b0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= cnt_next[i];
      o_level   <= level_next;
      o_rise    <= rise_next;
      o_fall    <= fall_next;
      o_pending <= (o_pending & ~i_pend_clr) | (rise_next & i_rise_en)
                 | (fall_next & i_fall_en);
      o_irq     <= |(o_pending & i_irq_en);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_pin <= OUT_RESET;
    end else if (i_out_we) begin
      o_pin <= (o_pin & ~i_out_mask) | (i_out & i_out_mask);
    end
  end

endmodule

// File: tb/tb_swervolf_gpio_bank.sv
// Directed self-checking bench for swervolf_gpio_bank (2 sync stages, debounce 4).
module tb_swervolf_gpio_bank;

  localparam logic [15:0] RST_PIN = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] i_pin = '0;
  logic [15:0] o_level, o_rise, o_fall, o_pending, o_pin;
  logic [15:0] i_rise_en = '0, i_fall_en = '0, i_irq_en = '0, i_pend_clr = '0;
  logic        o_irq;
  logic [15:0] i_out = '0, i_out_mask = '0;
  logic        i_out_we = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  swervolf_gpio_bank #(
    .IN_WIDTH(16), .OUT_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .OUT_RESET(RST_PIN)
  ) dut (
    .clk(clk), .rstn(rstn), .i_pin(i_pin),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .i_rise_en(i_rise_en), .i_fall_en(i_fall_en), .i_irq_en(i_irq_en),
    .i_pend_clr(i_pend_clr), .o_pending(o_pending), .o_irq(o_irq),
    .i_out(i_out), .i_out_mask(i_out_mask), .i_out_we(i_out_we), .o_pin(o_pin)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] pins);
    rstn = 1'b0;
    i_pin = pins;
    i_rise_en = '0; i_fall_en = '0; i_irq_en = '0; i_pend_clr = '0;
    i_out = '0; i_out_mask = '0; i_out_we = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_level, exp_rise;
    rstn = 1'b0;
    i_pin = 16'hFFFF;
    tick();
    tick();
    n_checks++;
    if (o_level !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_level got=%h exp=%h", o_level, 16'h0000); end
    n_checks++;
    if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_pending got=%h exp=%h", o_pending, 16'h0000); end
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got=%b exp=0", o_irq); end
    n_checks++;
    if (o_pin !== RST_PIN) begin n_fail++; $display("[TB] FAIL reset_pin got=%h exp=%h", o_pin, RST_PIN); end
    rstn = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_level = (t >= 6) ? 16'hFFFF : 16'h0000;
      exp_rise  = (t == 6) ? 16'hFFFF : 16'h0000;
      n_checks++;
      if (o_level !== exp_level) begin n_fail++; $display("[TB] FAIL release_level edge=%0d got=%h exp=%h", t, o_level, exp_level); end
      n_checks++;
      if (o_rise !== exp_rise) begin n_fail++; $display("[TB] FAIL release_rise edge=%0d got=%h exp=%h", t, o_rise, exp_rise); end
      n_checks++;
      if (o_fall !== 16'h0000) begin n_fail++; $display("[TB] FAIL release_fall edge=%0d got=%h exp=0000", t, o_fall); end
      n_checks++;
      if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL release_pending edge=%0d got=%h exp=0000", t, o_pending); end
    end
  endtask

  task automatic test_glitch();
    do_reset(16'h0000);
    tick();
    i_pin[3] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3) i_pin[3] = 1'b0;
      n_checks++;
      if (o_level[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_level edge=%0d got=%b exp=0", t, o_level[3]); end
      n_checks++;
      if (o_rise !== 16'h0000) begin n_fail++; $display("[TB] FAIL glitch_rise edge=%0d got=%h exp=0000", t, o_rise); end
    end
    i_pin[3] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      n_checks++;
      if (o_level[3] !== (t >= 6)) begin n_fail++; $display("[TB] FAIL hold_level edge=%0d got=%b exp=%b", t, o_level[3], (t >= 6)); end
      n_checks++;
      if (o_rise !== ((t == 6) ? 16'h0008 : 16'h0000)) begin n_fail++; $display("[TB] FAIL hold_rise edge=%0d got=%h", t, o_rise); end
    end
  endtask

  task automatic test_irq();
    do_reset(16'h0000);
    i_rise_en[0] = 1'b1;
    i_irq_en[0]  = 1'b1;
    i_pin[0]     = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++;
      if (o_pending[0] !== (t == 6)) begin n_fail++; $display("[TB] FAIL irq_pending edge=%0d got=%b exp=%b", t, o_pending[0], (t == 6)); end
      n_checks++;
      if (o_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_early edge=%0d got=%b exp=0", t, o_irq); end
    end
    n_checks++;
    if (o_rise !== 16'h0001) begin n_fail++; $display("[TB] FAIL irq_rise got=%h exp=0001", o_rise); end
    tick();
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_raise got=%b exp=1", o_irq); end
    i_irq_en[0] = 1'b0;
    tick();
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_masked got=%b exp=0", o_irq); end
    n_checks++;
    if (o_pending !== 16'h0001) begin n_fail++; $display("[TB] FAIL irq_mask_keeps_pending got=%h exp=0001", o_pending); end
    i_irq_en[0] = 1'b1;
    tick();
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_unmasked got=%b exp=1", o_irq); end
    i_pend_clr[0] = 1'b1;
    tick();
    i_pend_clr[0] = 1'b0;
    n_checks++;
    if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL irq_clear_pending got=%h exp=0000", o_pending); end
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_clear_lag got=%b exp=1", o_irq); end
    tick();
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_drop got=%b exp=0", o_irq); end
  endtask

  task automatic test_set_clear_collision();
    do_reset(16'h0000);
    i_fall_en[5] = 1'b1;
    i_pin[5] = 1'b1;
    repeat (7) tick();
    n_checks++;
    if (o_level !== 16'h0020) begin n_fail++; $display("[TB] FAIL coll_level_up got=%h exp=0020", o_level); end
    n_checks++;
    if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL coll_rise_not_enabled got=%h exp=0000", o_pending); end
    i_pin[5] = 1'b0;
    repeat (5) tick();
    i_pend_clr[5] = 1'b1;
    tick();
    i_pend_clr[5] = 1'b0;
    n_checks++;
    if (o_fall !== 16'h0020) begin n_fail++; $display("[TB] FAIL coll_fall got=%h exp=0020", o_fall); end
    n_checks++;
    if (o_pending !== 16'h0020) begin n_fail++; $display("[TB] FAIL coll_set_wins got=%h exp=0020", o_pending); end
    tick();
    n_checks++;
    if (o_pending !== 16'h0020) begin n_fail++; $display("[TB] FAIL coll_hold got=%h exp=0020", o_pending); end
    i_pend_clr[5] = 1'b1;
    tick();
    i_pend_clr[5] = 1'b0;
    n_checks++;
    if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL coll_clear got=%h exp=0000", o_pending); end
  endtask

  task automatic test_masked_write();
    do_reset(16'h0000);
    i_out = 16'h00FF; i_out_mask = 16'hFFFF; i_out_we = 1'b1;
    tick();
    n_checks++;
    if (o_pin !== 16'h00FF) begin n_fail++; $display("[TB] FAIL write_full got=%h exp=00FF", o_pin); end
    i_out = 16'hAAAA; i_out_mask = 16'h0F0F;
    tick();
    n_checks++;
    if (o_pin !== 16'h0AFA) begin n_fail++; $display("[TB] FAIL write_masked got=%h exp=0AFA", o_pin); end
    i_out = 16'h5555; i_out_mask = 16'hFFFF; i_out_we = 1'b0;
    tick();
    n_checks++;
    if (o_pin !== 16'h0AFA) begin n_fail++; $display("[TB] FAIL write_no_we got=%h exp=0AFA", o_pin); end
    i_out_mask = 16'h0000; i_out_we = 1'b1;
    tick();
    i_out_we = 1'b0;
    n_checks++;
    if (o_pin !== 16'h0AFA) begin n_fail++; $display("[TB] FAIL write_zero_mask got=%h exp=0AFA", o_pin); end
  endtask

  task automatic test_async_reset();
    do_reset(16'h0000);
    i_rise_en = 16'hFFFF; i_irq_en = 16'hFFFF;
    i_out = 16'h1234; i_out_mask = 16'hFFFF; i_out_we = 1'b1;
    i_pin[1] = 1'b1;
    tick();
    i_out_we = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (o_pending !== 16'h0002) begin n_fail++; $display("[TB] FAIL ar_pending_pre got=%h exp=0002", o_pending); end
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_irq_pre got=%b exp=1", o_irq); end
    n_checks++;
    if (o_pin !== 16'h1234) begin n_fail++; $display("[TB] FAIL ar_pin_pre got=%h exp=1234", o_pin); end
    i_pin[7] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (o_level !== 16'h0002) begin n_fail++; $display("[TB] FAIL ar_level_mid got=%h exp=0002", o_level); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (o_level !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_level got=%h exp=0000", o_level); end
    n_checks++;
    if (o_pending !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_pending got=%h exp=0000", o_pending); end
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_irq got=%b exp=0", o_irq); end
    n_checks++;
    if (o_pin !== RST_PIN) begin n_fail++; $display("[TB] FAIL ar_pin got=%h exp=%h", o_pin, RST_PIN); end
    tick();
    rstn = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++;
      if (o_level !== ((t == 6) ? 16'h0082 : 16'h0000)) begin n_fail++; $display("[TB] FAIL ar_relatch edge=%0d got=%h", t, o_level); end
    end
    n_checks++;
    if (o_rise !== 16'h0082) begin n_fail++; $display("[TB] FAIL ar_rise got=%h exp=0082", o_rise); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_irq();
    test_set_clear_collision();
    test_masked_write();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
